icap_multiboot_seq: RTL



---
 rtl/icap_pkg.sv | 39 +++
 rtl/icap_seq_rom.sv | 34 +++
 rtl/icap_multiboot_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/icap_pkg.sv
// Shared constants for the Spartan-6 IPROG command stream: packet words, FSM
// state codes and the per-byte bit reversal the ICAP data port expects.
package icap_pkg;

  localparam logic [15:0] DUMMY_WORD = 16'hFFFF;
  localparam logic [15:0] SYNC_WORD0 = 16'hAA99;
  localparam logic [15:0] SYNC_WORD1 = 16'h5566;
  localparam logic [15:0] NOOP_WORD  = 16'h2000;

  // Type-1 single-word write headers
  localparam logic [15:0] HDR_GENERAL1 = 16'h3261;
  localparam logic [15:0] HDR_GENERAL2 = 16'h3281;
  localparam logic [15:0] HDR_GENERAL3 = 16'h32A1;
  localparam logic [15:0] HDR_GENERAL4 = 16'h32C1;
  localparam logic [15:0] HDR_CMD      = 16'h30A1;

  localparam logic [15:0] CMD_IPROG = 16'h000E;

  localparam logic [3:0] LAST_WORD = 4'd13;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_CE_OFF = 3'd3;
  localparam logic [2:0] ST_WR_OFF = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  function automatic logic [15:0] bitswap16(input logic [15:0] d);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i]     = d[7-i];
      r[8 + i] = d[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_seq_rom.sv
// Word table of the IPROG sequence: maps word index and boot address to the
// pre-swap 16-bit word written into the ICAP.
module icap_seq_rom
  import icap_pkg::*;
#(
  parameter logic [23:0] GOLDEN_ADDR   = 24'h000000,
  parameter logic [7:0]  SPI_RD_OPCODE = 8'h03
) (
  input  logic [3:0]  w_i,
  input  logic [23:0] addr_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = NOOP_WORD;
    case (w_i)
      4'd0:    word_o = DUMMY_WORD;
      4'd1:    word_o = SYNC_WORD0;
      4'd2:    word_o = SYNC_WORD1;
      4'd3:    word_o = HDR_GENERAL1;
      4'd4:    word_o = addr_i[15:0];
      4'd5:    word_o = HDR_GENERAL2;
      4'd6:    word_o = {SPI_RD_OPCODE, addr_i[23:16]};
      4'd7:    word_o = HDR_GENERAL3;
      4'd8:    word_o = GOLDEN_ADDR[15:0];
      4'd9:    word_o = HDR_GENERAL4;
      4'd10:   word_o = {SPI_RD_OPCODE, GOLDEN_ADDR[23:16]};
      4'd11:   word_o = HDR_CMD;
      4'd12:   word_o = CMD_IPROG;
      default: word_o = NOOP_WORD;
    endcase
  end

endmodule

// File: rtl/icap_multiboot_seq.sv
// Multiboot reboot sequencer: streams the IPROG packet for the selected flash
// image into ICAP_SPARTAN6, honouring BUSY with a timeout, then reports done/err.
module icap_multiboot_seq
  import icap_pkg::*;
#(
  parameter int                         NUM_IMAGES    = 4,
  parameter logic [24*NUM_IMAGES-1:0]   IMAGE_ADDR    = {24'h400000, 24'h200000,
                                                         24'h100000, 24'h000000},
  parameter logic [23:0]                GOLDEN_ADDR   = 24'h000000,
  parameter logic [7:0]                 SPI_RD_OPCODE = 8'h03,
  parameter int                         BITSWAP       = 1,
  parameter int                         BUSY_TMO      = 255
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  slot,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        icap_ce_n,
  output logic        icap_write_n,
  output logic [15:0] icap_i,
  input  logic        icap_busy
);

  localparam logic [4:0]  NUM_IMG_L = 5'(NUM_IMAGES);
  localparam logic [15:0] TMO_LIMIT = 16'(BUSY_TMO);

  logic [2:0]  state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [23:0] addr_q, addr_d;
  logic [3:0]  w_q, w_d;
  logic [15:0] tmo_q, tmo_d;
  logic        abort_q, abort_d;
  logic        ce_n_q, ce_n_d;
  logic        wr_n_q, wr_n_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [15:0] rom_word;
  logic [15:0] out_word;

  // Unused slots read as zero; they are rejected before the table is used.
  logic [23:0] img_tbl [16];
  for (genvar k = 0; k < 16; k++) begin : g_img
    if (k < NUM_IMAGES) begin : g_on
      assign img_tbl[k] = IMAGE_ADDR[24*k +: 24];
    end else begin : g_off
      assign img_tbl[k] = '0;
    end
  end

  icap_seq_rom #(
    .GOLDEN_ADDR   (GOLDEN_ADDR),
    .SPI_RD_OPCODE (SPI_RD_OPCODE)
  ) u_rom (
    .w_i    (w_d),
    .addr_i (addr_d),
    .word_o (rom_word)
  );

  assign out_word = (BITSWAP != 0) ? bitswap16(rom_word) : rom_word;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    w_d     = w_q;
    tmo_d   = tmo_q;
    abort_d = abort_q;
    ce_n_d  = ce_n_q;
    wr_n_d  = wr_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          slot_d  = slot;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_d     = '0;
        tmo_d   = '0;
        abort_d = 1'b0;
        if ({1'b0, slot_q} < NUM_IMG_L) begin
          addr_d  = img_tbl[slot_q];
          ce_n_d  = 1'b0;
          wr_n_d  = 1'b0;
          state_d = ST_WRITE;
        end else begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_ERR;
        end
      end
      ST_WRITE: begin
        if (icap_busy) begin
          // BUSY_TMO stalled cycles are tolerated; one more aborts the packet.
          if (tmo_q == TMO_LIMIT) begin
            abort_d = 1'b1;
            ce_n_d  = 1'b1;
            state_d = ST_CE_OFF;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end else begin
          tmo_d = '0;
          if (w_q == LAST_WORD) begin
            ce_n_d  = 1'b1;
            state_d = ST_CE_OFF;
          end else begin
            w_d = w_q + 4'd1;
          end
        end
      end
      ST_CE_OFF: begin
        wr_n_d  = 1'b1;
        state_d = ST_WR_OFF;
      end
      ST_WR_OFF: begin
        busy_d = 1'b0;
        if (abort_q) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase

    // WRITE only ever changes while CE is high, so data is reloaded only when CE stays low.
    data_d = ce_n_d ? data_q : out_word;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values; reset is asynchronous and takes effect immediately.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      addr_q  <= '0;
      w_q     <= '0;
      tmo_q   <= '0;
      abort_q <= 1'b0;
      ce_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      data_q  <= DUMMY_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
      ce_n_q  <= ce_n_d;
      wr_n_q  <= wr_n_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign icap_ce_n    = ce_n_q;
  assign icap_write_n = wr_n_q;
  assign icap_i       = data_q;

endmodule
